// File: rtl/collision_scheduler_pkg.sv
// collision_scheduler_pkg: shared FSM encoding, ground height and coordinate width.
package collision_scheduler_pkg;
  localparam int COORD_W_DEF = 9;
  localparam logic [COORD_W_DEF-1:0] GROUND_Y = 9'd220;
  typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;
endpackage

// File: rtl/collision_scheduler_bbox_overlap.sv
// bbox_overlap: inclusive unsigned overlap test between an occupied wall box and the bird box.
module bbox_overlap #(
  parameter int W = 9
) (
  input  logic         i_valid,
  input  logic [W-1:0] i_a_xl,
  input  logic [W-1:0] i_a_xr,
  input  logic [W-1:0] i_a_yt,
  input  logic [W-1:0] i_a_yb,
  input  logic [W-1:0] i_b_xl,
  input  logic [W-1:0] i_b_xr,
  input  logic [W-1:0] i_b_yt,
  input  logic [W-1:0] i_b_yb,
  output logic         o_hit
);
  assign o_hit = i_valid && i_a_xr >= i_b_xl && i_a_xl <= i_b_xr && i_a_yb >= i_b_yt && i_a_yt <= i_b_yb;
endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler: scans wall slots once per frame against a latched bird box.
// Define GROUND_CHECK_EN to also flag ground/ceiling contact as a hit.
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int NUM_WALLS = 4,
  parameter int COORD_W = COORD_W_DEF,
  localparam int IDX_W = NUM_WALLS > 1 ? $clog2(NUM_WALLS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] bird_xleft,
  input  logic [COORD_W-1:0] bird_xright,
  input  logic [COORD_W-1:0] bird_ytop,
  input  logic [COORD_W-1:0] bird_ybottom,
  output logic [IDX_W-1:0]   wall_idx,
  input  logic               wall_valid,
  input  logic [COORD_W-1:0] wall_xleft,
  input  logic [COORD_W-1:0] wall_xright,
  input  logic [COORD_W-1:0] wall_ytop,
  input  logic [COORD_W-1:0] wall_ybottom,
  input  logic               game_clear,
  output logic               busy,
  output logic               done,
  output logic               touched,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               game_over
);
  state_t             r_state;
  logic [COORD_W-1:0] r_bxl, r_bxr, r_byt, r_byb;
  logic [IDX_W-1:0]   r_wall_idx, r_first_idx, r_hit_idx;
  logic               r_hit, r_done, r_touched, r_game_over;
  logic               w_slot_hit, w_last, w_wall_hit, w_ground, w_scan_hit;
  logic [IDX_W-1:0]   w_wall_idx;
  bbox_overlap #(.W(COORD_W)) u_overlap (
    .i_valid(wall_valid),
    .i_a_xl(r_bxl),
    .i_a_xr(r_bxr),
    .i_a_yt(r_byt),
    .i_a_yb(r_byb),
    .i_b_xl(wall_xleft),
    .i_b_xr(wall_xright),
    .i_b_yt(wall_ytop),
    .i_b_yb(wall_ybottom),
    .o_hit(w_slot_hit)
  );
  // The last slot's result is folded in combinationally so results are valid alongside done.
  assign w_last     = r_state == SCAN && r_wall_idx == IDX_W'(NUM_WALLS - 1);
  assign w_wall_hit = r_hit | w_slot_hit;
  assign w_wall_idx = r_hit ? r_first_idx : (w_slot_hit ? r_wall_idx : '0);
`ifdef GROUND_CHECK_EN
  assign w_ground = r_byb >= COORD_W'(GROUND_Y) || r_byt == '0;
`else
  assign w_ground = 1'b0;
`endif
  assign w_scan_hit = w_wall_hit | w_ground;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bxl       <= '0;
      r_bxr       <= '0;
      r_byt       <= '0;
      r_byb       <= '0;
      r_wall_idx  <= '0;
      r_first_idx <= '0;
      r_hit_idx   <= '0;
      r_hit       <= 1'b0;
      r_done      <= 1'b0;
      r_touched   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_done      <= w_last;
      r_game_over <= (w_last & w_scan_hit) | (r_game_over & ~game_clear);
      case (r_state)
        IDLE: r_state <= frame_start ? LATCH : IDLE;
        LATCH: begin
          r_bxl       <= bird_xleft;
          r_bxr       <= bird_xright;
          r_byt       <= bird_ytop;
          r_byb       <= bird_ybottom;
          r_hit       <= 1'b0;
          r_first_idx <= '0;
          r_wall_idx  <= '0;
          r_state     <= SCAN;
        end
        SCAN: begin
          if (w_slot_hit && !r_hit) begin
            r_hit       <= 1'b1;
            r_first_idx <= r_wall_idx;
          end
          if (w_last) begin
            r_state   <= DONE;
            r_touched <= w_scan_hit;
            r_hit_idx <= w_wall_idx;
          end else begin
            r_wall_idx <= r_wall_idx + 1'b1;
          end
        end
        DONE: begin
          r_wall_idx <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign wall_idx  = r_wall_idx;
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign touched   = r_touched;
  assign hit_idx   = r_hit_idx;
  assign game_over = r_game_over;
endmodule
